avg_down2x: RTL

Streaming 2×2 box-filter downscaler between the image ROM and the single-port framebuffer RAM. On `start` it reads the full SRC_W×SRC_H 8-bit ROM image in 2×2 blocks, averages each block, and writes the (SRC_W/2)×(SRC_H/2) result into RAM in raster order. It is the zoom-out counterpart of the pixel-replication stage. It drives the RAM address/data/wren path until `done` hands the RAM back to the VGA read side.

---
 rtl/avg_down2x.sv | 138 +++++++++++++
 1 files changed

// File: rtl/avg_down2x.sv
// avg_down2x: streams a SRC_W x SRC_H ROM image through a 2x2 box filter
// and writes the half-size result into the framebuffer RAM in raster order.
module avg_down2x #(
    parameter int SRC_W   = 320,
    parameter int SRC_H   = 240,
    parameter int ADDR_W  = 19,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_pixel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = SRC_W / 2;
    localparam int OUT_H = SRC_H / 2;
    localparam int N     = OUT_W * OUT_H;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic               go;
    logic               issue;
    logic               last_issue;
    logic               last_write;
    logic               cap;
    logic [1:0]         phase;
    logic [1:0]         cap_ph;
    logic [ADDR_W-1:0]  ox;
    logic [ADDR_W-1:0]  blk;
    logic [ADDR_W-1:0]  wcnt;
    logic [ROM_LAT-1:0] vld;
    logic [9:0]         acc;
    logic [9:0]         sum;

    assign go         = start && (state == IDLE || state == DONE);
    assign issue      = (state == RUN);
    assign last_issue = issue && phase == 2'd3 && blk == ADDR_W'(N - 1);
    assign last_write = ram_wren && ram_addr == ADDR_W'(N - 1);
    assign cap        = vld[ROM_LAT-1];
    assign sum        = (cap_ph == 2'd0 ? 10'd0 : acc) + {2'b00, rom_pixel};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)      state_nxt = RUN;
            RUN:   if (last_issue) state_nxt = DRAIN;
            DRAIN: if (last_write) state_nxt = DONE;
            DONE:  if (start)      state_nxt = RUN;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Block-ordered address walk built from the four fixed strides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            phase    <= 2'd0;
            ox       <= '0;
            blk      <= '0;
        end else if (go) begin
            rom_addr <= '0;
            phase    <= 2'd0;
            ox       <= '0;
            blk      <= '0;
        end else if (issue && !last_issue) begin
            phase <= phase + 2'd1;
            unique case (phase)
                2'd0: rom_addr <= rom_addr + ADDR_W'(1);
                2'd1: rom_addr <= rom_addr + ADDR_W'(SRC_W - 1);
                2'd2: rom_addr <= rom_addr + ADDR_W'(1);
                2'd3: begin
                    blk <= blk + ADDR_W'(1);
                    if (ox == ADDR_W'(OUT_W - 1)) begin
                        ox       <= '0;
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end else begin
                        ox       <= ox + ADDR_W'(1);
                        rom_addr <= rom_addr - ADDR_W'(SRC_W - 1);
                    end
                end
            endcase
        end
    end

    // Returning samples arrive in issue order, so a phase counter suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            cap_ph   <= 2'd0;
            acc      <= '0;
            wcnt     <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
        end else begin
            vld      <= ROM_LAT'({vld, issue});
            ram_wren <= cap && cap_ph == 2'd3;
            if (go) begin
                cap_ph <= 2'd0;
                wcnt   <= '0;
            end else if (cap) begin
                acc    <= sum;
                cap_ph <= cap_ph + 2'd1;
                if (cap_ph == 2'd3) begin
                    ram_addr <= wcnt;
                    ram_data <= sum[9:2];
                    wcnt     <= wcnt + ADDR_W'(1);
                end
            end
        end
    end

endmodule
